// File: rtl/seq_monitor_if.sv
// Sample/control and status bundle between an upstream 3-bit counter checker client and seq_monitor.
// The master drives the sampled counter bits and controls; the slave returns lock/error status and counts.
interface seq_monitor_if #(
  parameter int CNT_W = 8
);
  logic             q1;
  logic             q2;
  logic             q3;
  logic             in_valid;
  logic             clr;
  logic             locked;
  logic             err;
  logic [7:0]       onehot;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] wrap_cnt;

  modport master (
    output q1, q2, q3, in_valid, clr,
    input  locked, err, onehot, mismatch_cnt, wrap_cnt
  );

  modport slave (
    input  q1, q2, q3, in_valid, clr,
    output locked, err, onehot, mismatch_cnt, wrap_cnt
  );
endinterface

// File: rtl/seq_monitor.sv
// Watches a 3-bit up-counter sample stream, locks after LOCK_N clean increments and flags
// a sticky error after ERR_N consecutive bad steps while locked.
module seq_monitor #(
  parameter int LOCK_N = 3,
  parameter int ERR_N  = 2,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED, ERROR} state_t;

  localparam logic [3:0] LOCK_T = LOCK_N[3:0];
  localparam logic [3:0] ERR_T  = ERR_N[3:0];

  state_t           state_reg;
  logic [2:0]       prev_reg;
  logic [3:0]       streak_reg;
  logic [3:0]       bad_reg;
  logic             locked_reg;
  logic             err_reg;
  logic [7:0]       onehot_reg;
  logic [CNT_W-1:0] mcnt_reg;
  logic [CNT_W-1:0] wcnt_reg;

  logic [2:0] code;
  logic [2:0] exp_code;
  logic       match;
  logic [3:0] streak_next;
  logic [3:0] bad_next;

  assign code        = {bus.q3, bus.q2, bus.q1};
  assign exp_code    = prev_reg + 3'd1;
  assign match       = (code == exp_code);
  assign streak_next = streak_reg + 4'd1;
  assign bad_next    = bad_reg + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      prev_reg   <= '0;
      streak_reg <= '0;
      bad_reg    <= '0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
      onehot_reg <= '0;
      mcnt_reg   <= '0;
      wcnt_reg   <= '0;
    end else if (bus.clr) begin
      // clr wins over a coincident sample; that sample is discarded
      state_reg  <= IDLE;
      prev_reg   <= '0;
      streak_reg <= '0;
      bad_reg    <= '0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
      onehot_reg <= '0;
      mcnt_reg   <= '0;
      wcnt_reg   <= '0;
    end else if (bus.in_valid) begin
      prev_reg   <= code;
      onehot_reg <= 8'd1 << code;
      case (state_reg)
        IDLE: begin
          streak_reg <= '0;
          state_reg  <= SYNC;
        end
        SYNC: begin
          if (match) begin
            streak_reg <= streak_next;
            if (streak_next >= LOCK_T) begin
              state_reg  <= LOCKED;
              locked_reg <= 1'b1;
              bad_reg    <= '0;
            end
          end else begin
            streak_reg <= '0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_reg <= '0;
            if (prev_reg == 3'd7) wcnt_reg <= wcnt_reg + 1'b1;
          end else begin
            bad_reg <= bad_next;
            if (mcnt_reg != '1) mcnt_reg <= mcnt_reg + 1'b1;
            if (bad_next >= ERR_T) begin
              state_reg  <= ERROR;
              locked_reg <= 1'b0;
              err_reg    <= 1'b1;
            end
          end
        end
        ERROR: begin
          // recovery restarts sync with this matching step already counted
          if (match) begin
            streak_reg <= 4'd1;
            state_reg  <= SYNC;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.locked       = locked_reg;
  assign bus.err          = err_reg;
  assign bus.onehot       = onehot_reg;
  assign bus.mismatch_cnt = mcnt_reg;
  assign bus.wrap_cnt     = wcnt_reg;
endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor: directed scenarios plus randomized samples
// compared against a rule-level model of the lock/error behaviour.
module tb_seq_monitor;
  localparam int CNT_W = 8;
  localparam int LOCK_N = 3;
  localparam int ERR_N = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_monitor_if #(.CNT_W(CNT_W)) bus();

  seq_monitor #(.LOCK_N(LOCK_N), .ERR_N(ERR_N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: mode 0=idle 1=sync 2=locked 3=error
  int m_mode, m_prev, m_streak, m_bad, m_mcnt, m_wcnt, m_err, m_onehot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_prev = 0; m_streak = 0; m_bad = 0;
    m_mcnt = 0; m_wcnt = 0; m_err = 0; m_onehot = 0;
  endfunction

  function automatic void model_step(input bit v, input int code, input bit c);
    bit match;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
    match = (code == (m_prev + 1) % 8);
    case (m_mode)
      0: begin m_mode = 1; m_streak = 0; end
      1: begin
        if (match) begin
          m_streak++;
          if (m_streak >= LOCK_N) begin m_mode = 2; m_bad = 0; end
        end else m_streak = 0;
      end
      2: begin
        if (match) begin
          m_bad = 0;
          if (m_prev == 7) m_wcnt = (m_wcnt + 1) % (1 << CNT_W);
        end else begin
          m_bad++;
          if (m_mcnt < (1 << CNT_W) - 1) m_mcnt++;
          if (m_bad >= ERR_N) begin m_mode = 3; m_err = 1; end
        end
      end
      default: if (match) begin m_mode = 1; m_streak = 1; end
    endcase
    m_prev = code;
    m_onehot = 1 << code;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_locked"}, 32'(bus.locked), 32'(m_mode == 2));
    chk({tag, "_err"}, 32'(bus.err), 32'(m_err));
    chk({tag, "_onehot"}, 32'(bus.onehot), 32'(m_onehot));
    chk({tag, "_mcnt"}, 32'(bus.mismatch_cnt), 32'(m_mcnt));
    chk({tag, "_wcnt"}, 32'(bus.wrap_cnt), 32'(m_wcnt));
  endtask

  task automatic drive(input bit v, input int code, input bit c, input string tag);
    logic [2:0] cb;
    cb = code[2:0];
    @(negedge clk);
    bus.in_valid = v;
    bus.clr = c;
    bus.q1 = cb[0];
    bus.q2 = cb[1];
    bus.q3 = cb[2];
    @(posedge clk);
    model_step(v, code, c);
    #1;
    check_all(tag);
    $display("%s v=%0b code=%0d clr=%0b -> locked=%0b err=%0b onehot=%02h mcnt=%0d wcnt=%0d",
             tag, v, code, c, bus.locked, bus.err, bus.onehot, bus.mismatch_cnt, bus.wrap_cnt);
  endtask

  task automatic feed(input int code, input string tag);
    drive(1'b1, code, 1'b0, tag);
  endtask

  initial begin
    int code;
    bit v, c;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.clr = 1'b0;
    bus.q1 = 1'b0; bus.q2 = 1'b0; bus.q3 = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // lock on 0,1,2,3
    feed(0, "lock0"); feed(1, "lock1"); feed(2, "lock2");
    chk("lock2_not_locked", 32'(bus.locked), 32'd0);
    feed(3, "lock3");
    chk("lock_locked", 32'(bus.locked), 32'd1);
    chk("lock_onehot", 32'(bus.onehot), 32'h08);

    // wrap through 7->0
    feed(4, "wrap"); feed(5, "wrap"); feed(6, "wrap");
    feed(7, "wrap"); feed(0, "wrap"); feed(1, "wrap");
    chk("wrap_cnt", 32'(bus.wrap_cnt), 32'd1);
    chk("wrap_onehot", 32'(bus.onehot), 32'h02);

    // idle cycles change nothing
    drive(1'b0, 6, 1'b0, "hold");
    chk("hold_onehot", 32'(bus.onehot), 32'h02);

    // mismatches while locked
    feed(2, "mis"); feed(5, "mis"); feed(6, "mis");
    chk("mis_locked", 32'(bus.locked), 32'd1);
    chk("mis_cnt1", 32'(bus.mismatch_cnt), 32'd1);
    feed(0, "mis"); feed(3, "mis");
    chk("mis_cnt3", 32'(bus.mismatch_cnt), 32'd3);
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_unlocked", 32'(bus.locked), 32'd0);

    // recover from error
    feed(4, "rec"); feed(5, "rec");
    chk("rec_not_locked", 32'(bus.locked), 32'd0);
    feed(6, "rec");
    chk("rec_locked", 32'(bus.locked), 32'd1);
    chk("rec_err_sticky", 32'(bus.err), 32'd1);

    // saturation of mismatch counter
    drive(1'b0, 0, 1'b1, "clr");
    feed(0, "sat"); feed(1, "sat"); feed(2, "sat"); feed(3, "sat");
    code = 3;
    for (int i = 0; i < 257; i++) begin
      code = (code + 2) % 8;
      feed(code, "sat_bad");
      code = (code + 1) % 8;
      feed(code, "sat_good");
    end
    chk("sat_cnt", 32'(bus.mismatch_cnt), 32'd255);
    chk("sat_locked", 32'(bus.locked), 32'd1);
    drive(1'b1, 5, 1'b1, "clr_valid");
    chk("clr_onehot", 32'(bus.onehot), 32'd0);
    chk("clr_cnt", 32'(bus.mismatch_cnt), 32'd0);

    // asynchronous reset while locked
    feed(0, "ar"); feed(1, "ar"); feed(2, "ar"); feed(3, "ar"); feed(4, "ar");
    feed(5, "ar"); feed(6, "ar"); feed(7, "ar"); feed(0, "ar");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    $display("async_reset -> locked=%0b err=%0b onehot=%02h wcnt=%0d",
             bus.locked, bus.err, bus.onehot, bus.wrap_cnt);
    @(negedge clk);
    reset = 1'b0;
    feed(5, "post_reset");
    chk("post_reset_onehot", 32'(bus.onehot), 32'h20);
    feed(6, "post_reset"); feed(7, "post_reset"); feed(0, "post_reset");
    chk("post_reset_locked", 32'(bus.locked), 32'd1);

    // randomized stream
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 8);
      code = ($urandom_range(0, 9) < 7) ? (m_prev + 1) % 8 : int'($urandom_range(0, 7));
      c = ($urandom_range(0, 199) == 0);
      drive(v, code, c, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter LOCK_N, default 3: consecutive correct transitions required to declare lock (1..15).
REQ-002 Parameter ERR_N, default 2: consecutive mismatches while locked that force ERROR (1..15).
REQ-003 Parameter CNT_W, default 8: width of both event counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 q1  input  1  bit 0 (LSB) of the upstream 3-bit counter state.
REQ-007 q2  input  1  bit 1 of the upstream counter state.
REQ-008 q3  input  1  bit 2 (MSB) of the upstream counter state.
REQ-009 in_valid  input  1  current {q3,q2,q1} is a sample to be checked.
REQ-010 clr  input  1  synchronous clear of state, counters and flags.
REQ-011 locked  output  1  high while the FSM is in LOCKED.
REQ-012 err  output  1  sticky error flag.
REQ-013 onehot  output  8  registered one-hot decode of the last valid sample.
REQ-014 mismatch_cnt  output  CNT_W  saturating count of mismatches seen while LOCKED.
REQ-015 wrap_cnt  output  CNT_W  wrapping count of 7->0 transitions seen while LOCKED.

Function
REQ-016 code = {q3,q2,q1}; expected next = (prev + 1) mod 8, where prev is the last valid code.
REQ-017 FSM states: IDLE, SYNC, LOCKED, ERROR; all outputs registered; visible after the edge that samples in_valid=1.
REQ-018 IDLE: on in_valid -> capture prev=code, streak=0, go SYNC; no checking on this first sample.
REQ-019 SYNC: valid & match -> streak+1; streak reaching LOCK_N -> LOCKED, bad=0; valid & mismatch -> streak=0, stay SYNC; mismatches not counted.
REQ-020 LOCKED: valid & match -> bad=0; valid & mismatch -> bad+1, mismatch_cnt+1 (saturates at all-ones); bad reaching ERR_N -> ERROR, err=1.
REQ-021 ERROR: valid & match -> SYNC with streak=1; valid & mismatch -> stay ERROR; err stays 1 until clr or reset.
REQ-022 wrap_cnt increments by 1 (mod 2^CNT_W) only in LOCKED on a valid matching transition prev=7 -> code=0.
REQ-023 prev updates to code on every valid sample in every state, match or not.
REQ-024 onehot = 1 << code on every valid sample; holds its value when in_valid=0.
REQ-025 in_valid=0: no state, counter or flag changes.
REQ-026 clr=1 at a clock edge -> IDLE, counters 0, err 0, onehot 0, streak/bad 0; clr overrides a simultaneous in_valid (sample dropped).
REQ-027 A transition to LOCKED and the mismatch that ends it are never in the same cycle; the entry cycle counts nothing.

Reset
REQ-028 reset=1 asynchronously forces IDLE, locked=0, err=0, onehot=8'h00, mismatch_cnt=0, wrap_cnt=0, prev=0, streak=0, bad=0, without waiting for clk.
REQ-029 Reset asserted mid-operation (any state) yields the same values; first valid sample after release is treated as IDLE capture.

Verification
REQ-030 Reset, then valid codes 0,1,2,3 -> locked=1 after the edge sampling 3; onehot=8'h08; counters 0.
REQ-031 Locked, feed 4,5,6,7,0,1 -> wrap_cnt=1, mismatch_cnt=0, locked stays 1, onehot=8'h02.
REQ-032 Locked at 2, feed 5, 6 -> mismatch_cnt=1, bad=0 after 6 (6 matches 5), locked=1; then 0, 3 -> mismatch_cnt=3, ERROR, locked=0, err=1.
REQ-033 In ERROR, feed 4 then 5 -> SYNC after 4, streak=2 after 5, err still 1; then 6 -> LOCKED, err remains 1 until clr.
REQ-034 mismatch_cnt at 255 (CNT_W=8) plus another locked mismatch -> stays 255; clr asserted with in_valid=1 -> all outputs 0, IDLE, sample ignored.
REQ-035 Assert reset between clock edges while LOCKED -> locked, err, onehot and counters 0 immediately, before the next rising clk.
